// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial transmitter, MSB first, one bit per clk.
// A one-word holding register allows gap-free back-to-back frames; flush aborts
// the frame in flight and drops any queued word.
// Optional feature macro: PARITY_EN appends one even-parity bit per frame.
module byte_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flush,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_valid, hold_valid_n;
`ifdef PARITY_EN
    logic             par, par_n;
`endif

    logic             accept;
    logic             eof;
    logic             end_frame;
    logic             start;
    logic [WIDTH-1:0] start_word;

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
`ifdef PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
`ifdef PARITY_EN
            par        <= par_n;
`endif
        end
    end

    // Line outputs decoded from the registered state
    always_comb begin
        ready     = !hold_valid;
        bit_valid = (state != IDLE);
        bit_out   = 1'b0;
`ifdef PARITY_EN
        eof = (state == PAR);
`else
        eof = (state == SHIFT) && (cnt == CNT_LAST);
`endif
        last = eof;
        case (state)
            SHIFT:   bit_out = shreg[WIDTH-1];
`ifdef PARITY_EN
            PAR:     bit_out = par;
`endif
            default: bit_out = 1'b0;
        endcase
    end

    // Next-state logic: shifting, queueing, frame chaining and flush
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shreg_n      = shreg;
        hold_n       = hold;
        hold_valid_n = hold_valid;
`ifdef PARITY_EN
        par_n        = par;
`endif
        accept       = load && !hold_valid && !flush;
        end_frame    = 1'b0;
        start        = 1'b0;
        start_word   = data_in;

        case (state)
            IDLE: begin
                if (accept) begin
                    start = 1'b1;
                end
            end
            SHIFT: begin
                // A load on the final data bit (no parity) is a bypass, not a queue
                if (accept && !eof) begin
                    hold_n       = data_in;
                    hold_valid_n = 1'b1;
                end
                if (cnt != CNT_LAST) begin
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    cnt_n   = cnt + CW'(1);
                end else begin
`ifdef PARITY_EN
                    state_n = PAR;
                    cnt_n   = '0;
`else
                    end_frame = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                end_frame = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        // Chain the next word with no gap: queued word first, else a same-cycle load
        if (end_frame) begin
            if (hold_valid) begin
                start        = 1'b1;
                start_word   = hold;
                hold_valid_n = 1'b0;
            end else if (accept) begin
                start = 1'b1;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
            end
        end

        if (start) begin
            state_n = SHIFT;
            cnt_n   = '0;
            shreg_n = start_word;
`ifdef PARITY_EN
            par_n   = ^start_word;
`endif
        end

        if (flush) begin
            state_n      = IDLE;
            cnt_n        = '0;
            shreg_n      = '0;
            hold_n       = '0;
            hold_valid_n = 1'b0;
`ifdef PARITY_EN
            par_n        = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer: directed scenarios plus randomized traffic
// checked against a queue-based model of the serial line.
module tb_byte_serializer;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready, bit_out, bit_valid, last;

    int passed = 0;
    int total  = 0;

    // Model: bits still to appear on the line, plus the queued word
    bit           mq[$];
    bit           m_hv = 1'b0;
    logic [W-1:0] m_hold = '0;

    byte_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .flush    (flush),
        .ready    (ready),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .last     (last)
    );

    always #5 clk = ~clk;

    function automatic void push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
`ifdef PARITY_EN
        mq.push_back(^w);
`endif
    endfunction

    function automatic void model_edge(input bit ld, input logic [W-1:0] d, input bit fl);
        bit acc;
        acc = ld && !m_hv;
        if (fl) begin
            mq.delete();
            m_hv = 1'b0;
            return;
        end
        if (mq.size() > 0) void'(mq.pop_front());
        if (mq.size() == 0) begin
            if (m_hv) begin
                push_frame(m_hold);
                m_hv = 1'b0;
            end else if (acc) begin
                push_frame(d);
            end
        end else if (acc) begin
            m_hold = d;
            m_hv   = 1'b1;
        end
    endfunction

    // {bit_valid, bit_out, last, ready} predicted by the model
    function automatic logic [3:0] m_out();
        logic [3:0] r;
        r[3] = (mq.size() > 0);
        r[2] = (mq.size() > 0) ? mq[0] : 1'b0;
        r[1] = (mq.size() == 1);
        r[0] = !m_hv;
        return r;
    endfunction

    function automatic logic [3:0] dut_out();
        return {bit_valid, bit_out, last, ready};
    endfunction

    task automatic tick(input bit ld, input logic [W-1:0] d, input bit fl);
        load    = ld;
        data_in = d;
        flush   = fl;
        model_edge(ld, d, fl);
        @(posedge clk);
        #1;
        load    = 1'b0;
        flush   = 1'b0;
        data_in = W'($urandom);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #2;
        got = dut_out();
        total++;
        if (got !== 4'b0001) $display("FAIL reset_init got %b exp %b", got, 4'b0001);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 8'hA5, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        got = dut_out();
        total++;
        if (got !== 4'b0001) $display("FAIL reset_midframe got %b exp %b", got, 4'b0001);
        else passed++;
        mq.delete();
        m_hv = 1'b0;
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, '0, 1'b0);
            got = dut_out();
            total++;
            if (got !== 4'b0001) $display("FAIL reset_idle cyc %0d got %b exp %b", c, got, 4'b0001);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        logic [3:0]   got, exp;
        w = 8'hA5;
        tick(1'b1, w, 1'b0);
        for (int c = 1; c <= FL + 1; c++) begin
            exp[3] = (c <= FL);
            exp[2] = (c <= W) ? w[W-c] : ((c == FL) ? ^w : 1'b0);
            exp[1] = (c == FL);
            exp[0] = 1'b1;
            got = dut_out();
            total++;
            if (got !== exp) $display("FAIL single cyc %0d got %b exp %b", c, got, exp);
            else passed++;
            tick(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]      got;
        logic [2*FL-1:0] stream, exp_s;
        int              nvalid;
`ifdef PARITY_EN
        exp_s = {8'h3C, 1'b0, 8'hF0, 1'b0};
`else
        exp_s = 16'h3CF0;
`endif
        stream = '0;
        nvalid = 0;
        tick(1'b1, 8'h3C, 1'b0);
        for (int c = 1; c <= 2 * FL + 2; c++) begin
            got = dut_out();
            total++;
            if (got !== m_out()) $display("FAIL b2b_model cyc %0d got %b exp %b", c, got, m_out());
            else passed++;
            total++;
            if (ready !== !(c >= 4 && c <= FL)) $display("FAIL b2b_ready cyc %0d got %b exp %b", c, ready, !(c >= 4 && c <= FL));
            else passed++;
            if (c <= 2 * FL) begin
                if (bit_valid === 1'b1) nvalid++;
                stream = {stream[2*FL-2:0], bit_out};
            end
            tick(c == 3, 8'hF0, 1'b0);
        end
        total++;
        if (nvalid != 2 * FL || stream !== exp_s)
            $display("FAIL b2b_stream got %b (%0d valid) exp %b (%0d valid)", stream, nvalid, exp_s, 2 * FL);
        else passed++;
    endtask

    task automatic test_flush();
        logic [3:0] got;
        tick(1'b1, 8'hFF, 1'b0);
        for (int c = 1; c <= 25; c++) begin
            got = dut_out();
            total++;
            if (c >= 5) begin
                if (got !== 4'b0001) $display("FAIL flush_idle cyc %0d got %b exp %b", c, got, 4'b0001);
                else passed++;
            end else begin
                if (got !== m_out()) $display("FAIL flush_model cyc %0d got %b exp %b", c, got, m_out());
                else passed++;
            end
            tick(c == 2, 8'h0F, c == 4);
        end
    endtask

    task automatic test_bypass();
        logic [3:0]      got;
        logic [2*FL-1:0] stream, exp_s;
`ifdef PARITY_EN
        exp_s = {8'h81, 1'b0, 8'h42, 1'b0};
`else
        exp_s = 16'h8142;
`endif
        stream = '0;
        tick(1'b1, 8'h81, 1'b0);
        for (int c = 1; c <= 2 * FL + 1; c++) begin
            got = dut_out();
            total++;
            if (got !== m_out()) $display("FAIL bypass_model cyc %0d got %b exp %b", c, got, m_out());
            else passed++;
            total++;
            if (ready !== 1'b1 || bit_valid !== (c <= 2 * FL))
                $display("FAIL bypass_flow cyc %0d got ready=%b valid=%b exp ready=1 valid=%b", c, ready, bit_valid, c <= 2 * FL);
            else passed++;
            if (c <= 2 * FL) stream = {stream[2*FL-2:0], bit_out};
            tick(c == FL, 8'h42, 1'b0);
        end
        total++;
        if (stream !== exp_s) $display("FAIL bypass_stream got %b exp %b", stream, exp_s);
        else passed++;
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words[2];
        bit           pexp[2];
        logic [3:0]   got, exp;
        words[0] = 8'h07; pexp[0] = 1'b1;
        words[1] = 8'h03; pexp[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, words[k], 1'b0);
            for (int c = 1; c <= FL + 1; c++) begin
                exp[3] = (c <= FL);
                exp[2] = (c <= W) ? words[k][W-c] : ((c == FL) ? pexp[k] : 1'b0);
                exp[1] = (c == FL);
                exp[0] = 1'b1;
                got = dut_out();
                total++;
                if (got !== exp) $display("FAIL parity w%0h cyc %0d got %b exp %b", words[k], c, got, exp);
                else passed++;
                tick(1'b0, '0, 1'b0);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] got;
        bit         ld, fl;
        for (int c = 0; c < 800; c++) begin
            ld = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 39) == 0);
            tick(ld, W'($urandom), fl);
            got = dut_out();
            total++;
            if (got !== m_out()) $display("FAIL random cyc %0d got %b exp %b", c, got, m_out());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_bypass();
`ifdef PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
